// File: rtl/alu_iter_exec_if.sv
// Request/response bundle between the ALU-control decode and the execute stage.
interface alu_iter_exec_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       aluOP;
  logic             invA;
  logic             invB;
  logic             Cin;
  logic             sign;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ofl;
  logic             cout;

  modport master (
    output start, A, B, aluOP, invA, invB, Cin, sign,
    input  busy, done, result, zero, ofl, cout
  );

  modport slave (
    input  start, A, B, aluOP, invA, invB, Cin, sign,
    output busy, done, result, zero, ofl, cout
  );
endinterface

// File: rtl/alu_iter_exec.sv
// Execute stage: single-cycle ADD/XOR/AND, iterative one-bit-per-cycle
// shifts and rotates. Result and flags are registered; done pulses once
// per accepted start, busy covers the iterative shift cycles.
module alu_iter_exec #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_iter_exec_if.slave bus
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_ROR = 3'b001,
    OP_XOR = 3'b010,
    OP_AND = 3'b011,
    OP_SRA = 3'b100,
    OP_SRL = 3'b101,
    OP_ROL = 3'b110,
    OP_SLL = 3'b111
  } op_t;

  state_t             r_state;
  op_t                r_op;
  logic [WIDTH-1:0]   r_shreg;
  logic [SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_ofl;
  logic               r_cout;
  logic               r_busy;
  logic               r_done;

  op_t                w_op;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH:0]     w_sum;
  logic               w_ofl_signed;
  logic               w_is_shift;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_ofl;
  logic               w_alu_cout;
  logic [WIDTH-1:0]   w_step;

  // Operand preparation and single-cycle datapath (also yields raw A for N=0 shifts).
  always_comb begin
    w_op         = op_t'(bus.aluOP);
    w_a          = bus.invA ? ~bus.A : bus.A;
    w_b          = bus.invB ? ~bus.B : bus.B;
    w_sum        = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, bus.Cin};
    w_ofl_signed = (w_a[WIDTH-1] == w_b[WIDTH-1]) & (w_sum[WIDTH-1] != w_a[WIDTH-1]);
    w_shamt      = bus.B[SHAMT_W-1:0];
    w_is_shift   = 1'b1;
    w_alu_res    = bus.A;
    w_alu_ofl    = 1'b0;
    w_alu_cout   = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_is_shift = 1'b0;
        w_alu_res  = w_sum[WIDTH-1:0];
        w_alu_cout = w_sum[WIDTH];
        w_alu_ofl  = bus.sign ? w_ofl_signed : w_sum[WIDTH];
      end
      OP_XOR: begin
        w_is_shift = 1'b0;
        w_alu_res  = w_a ^ w_b;
      end
      OP_AND: begin
        w_is_shift = 1'b0;
        w_alu_res  = w_a & w_b;
      end
      default: ;
    endcase
  end

  // One-bit step of the latched shift/rotate operation.
  always_comb begin
    w_step = r_shreg;
    case (r_op)
      OP_SRA:  w_step = {r_shreg[WIDTH-1], r_shreg[WIDTH-1:1]};
      OP_SRL:  w_step = {1'b0, r_shreg[WIDTH-1:1]};
      OP_SLL:  w_step = {r_shreg[WIDTH-2:0], 1'b0};
      OP_ROL:  w_step = {r_shreg[WIDTH-2:0], r_shreg[WIDTH-1]};
      OP_ROR:  w_step = {r_shreg[0], r_shreg[WIDTH-1:1]};
      default: w_step = r_shreg;
    endcase
  end

  // Control FSM with registered result, flags, busy and done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_op     <= OP_ADD;
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ofl    <= 1'b0;
      r_cout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (!w_is_shift || (w_shamt == '0)) begin
              r_result <= w_alu_res;
              r_zero   <= (w_alu_res == '0);
              r_ofl    <= w_alu_ofl;
              r_cout   <= w_alu_cout;
              r_done   <= 1'b1;
            end else begin
              r_op    <= w_op;
              r_shreg <= bus.A;
              r_cnt   <= w_shamt;
              r_busy  <= 1'b1;
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_shreg <= w_step;
          r_cnt   <= r_cnt - 1'b1;
          if (r_cnt == SHAMT_W'(1)) begin
            r_result <= w_step;
            r_zero   <= (w_step == '0);
            r_ofl    <= 1'b0;
            r_cout   <= 1'b0;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.zero   = r_zero;
  assign bus.ofl    = r_ofl;
  assign bus.cout   = r_cout;

endmodule
